// File: rtl/sram_oq_write_ctrl.sv
// sram_oq_write_ctrl: admits or drops whole packets per queue free space, streams beats to QDR, publishes commit pointers.
// Latency: 1-cycle admission decision on the first beat, then beats pass combinationally to mem_wr_*.
// Backpressure: tready follows mem_wr_ack while writing, 1 while dropping. SRAM_OQ_WR_STATS_EN adds stat counters.
module sram_oq_write_ctrl #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES           = 5,
  parameter int MEM_ADDR_WIDTH       = 19,
  parameter int QUEUE_ADDR_WIDTH     = 16
) (
  input  logic                                         aclk,
  input  logic                                         aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]               s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]             s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]              s_axis_tuser,
  input  logic                                         s_axis_tvalid,
  output logic                                         s_axis_tready,
  input  logic                                         s_axis_tlast,
  output logic                                         mem_wr_req,
  input  logic                                         mem_wr_ack,
  output logic [MEM_ADDR_WIDTH-1:0]                    mem_wr_addr,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]               mem_wr_data,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]             mem_wr_strb,
  input  logic [NUM_QUEUES*(QUEUE_ADDR_WIDTH+1)-1:0]   rd_ptr_in,
  output logic [NUM_QUEUES*(QUEUE_ADDR_WIDTH+1)-1:0]   commit_ptr_out,
  output logic [NUM_QUEUES-1:0]                        pkt_committed
`ifdef SRAM_OQ_WR_STATS_EN
  ,
  output logic [31:0]                                  stat_pkt_in,
  output logic [31:0]                                  stat_pkt_drop,
  output logic [31:0]                                  stat_trunc
`endif
);

  localparam int PW      = QUEUE_ADDR_WIDTH + 1;
  localparam int QW      = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
  localparam int DST_LSB = 24;
  localparam logic [PW-1:0] Q_DEPTH = PW'(1) << QUEUE_ADDR_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  logic [1:0]            state;
  logic [QW-1:0]         cur_q;
  logic [PW-1:0]         wr_ptr     [NUM_QUEUES];
  logic [PW-1:0]         commit_ptr [NUM_QUEUES];
  logic [PW-1:0]         rd_ptr     [NUM_QUEUES];
  logic [PW-1:0]         free_words [NUM_QUEUES];

  logic [NUM_QUEUES-1:0] dst_onehot;
  logic                  dst_vld;
  logic [QW-1:0]         dst_q;
  logic [16:0]           pkt_words;
  logic                  admit;
  logic                  in_write;
  logic                  trunc;
  logic                  beat_wr;
  logic                  unused_tuser;

  assign dst_onehot   = s_axis_tuser[DST_LSB +: NUM_QUEUES];
  assign pkt_words    = ({1'b0, s_axis_tuser[15:0]} + 17'd31) >> 5;
  assign unused_tuser = ^s_axis_tuser;

  // Free space is recomputed every cycle so read-side progress is seen immediately.
  always_comb begin
    for (int i = 0; i < NUM_QUEUES; i++) begin
      rd_ptr[i]     = rd_ptr_in[i*PW +: PW];
      free_words[i] = Q_DEPTH - (wr_ptr[i] - rd_ptr[i]);
    end
  end

  always_comb begin
    commit_ptr_out = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      commit_ptr_out[i*PW +: PW] = commit_ptr[i];
    end
  end

  always_comb begin
    dst_vld = |dst_onehot;
    dst_q   = '0;
    for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
      if (dst_onehot[i]) dst_q = QW'(i);
    end
  end

  assign admit = dst_vld && (s_axis_tuser[15:0] != 16'd0) &&
                 (32'(pkt_words) <= 32'(free_words[dst_q]));

  // A non-final beat arriving with no room means the packet overran its declared length.
  assign in_write      = (state == ST_WRITE);
  assign trunc         = in_write && s_axis_tvalid && !s_axis_tlast && (free_words[cur_q] == '0);
  assign mem_wr_req    = in_write && s_axis_tvalid && !trunc;
  assign beat_wr       = mem_wr_req && mem_wr_ack;
  assign s_axis_tready = beat_wr || (state == ST_DROP);

  assign mem_wr_addr = (MEM_ADDR_WIDTH'(cur_q) << QUEUE_ADDR_WIDTH) |
                       MEM_ADDR_WIDTH'(wr_ptr[cur_q][QUEUE_ADDR_WIDTH-1:0]);
  assign mem_wr_data = s_axis_tdata;
  assign mem_wr_strb = s_axis_tstrb;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      cur_q         <= '0;
      pkt_committed <= '0;
      for (int i = 0; i < NUM_QUEUES; i++) begin
        wr_ptr[i]     <= '0;
        commit_ptr[i] <= '0;
      end
    end else begin
      pkt_committed <= '0;
      case (state)
        ST_IDLE: begin
          if (s_axis_tvalid) begin
            cur_q <= dst_q;
            state <= admit ? ST_WRITE : ST_DROP;
          end
        end
        ST_WRITE: begin
          if (trunc) begin
            wr_ptr[cur_q] <= commit_ptr[cur_q];
            state         <= ST_DROP;
          end else if (beat_wr) begin
            wr_ptr[cur_q] <= wr_ptr[cur_q] + PW'(1);
            if (s_axis_tlast) begin
              commit_ptr[cur_q]    <= wr_ptr[cur_q] + PW'(1);
              pkt_committed[cur_q] <= 1'b1;
              state                <= ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (s_axis_tvalid && s_axis_tlast) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SRAM_OQ_WR_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_pkt_in   <= '0;
      stat_pkt_drop <= '0;
      stat_trunc    <= '0;
    end else begin
      if ((state == ST_IDLE) && s_axis_tvalid) stat_pkt_in <= sat_inc(stat_pkt_in);
      if (((state == ST_IDLE) && s_axis_tvalid && !admit) || trunc) stat_pkt_drop <= sat_inc(stat_pkt_drop);
      if (trunc) stat_trunc <= sat_inc(stat_trunc);
    end
  end
`endif

endmodule

// File: tb/tb_sram_oq_write_ctrl.sv
// Bench for sram_oq_write_ctrl: table of packets plus hand sequences for wrap, overrun rollback and mid-packet reset.
module tb_sram_oq_write_ctrl;
  localparam int NQ = 5;
  localparam int PW = 17;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tstrb;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic         mem_wr_req;
  logic         mem_wr_ack;
  logic [18:0]  mem_wr_addr;
  logic [255:0] mem_wr_data;
  logic [31:0]  mem_wr_strb;
  logic [NQ*PW-1:0] rd_ptr_in;
  logic [NQ*PW-1:0] commit_ptr_out;
  logic [NQ-1:0]    pkt_committed;
`ifdef SRAM_OQ_WR_STATS_EN
  logic [31:0] stat_pkt_in, stat_pkt_drop, stat_trunc;
`endif

  sram_oq_write_ctrl dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .mem_wr_req(mem_wr_req), .mem_wr_ack(mem_wr_ack), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb),
    .rd_ptr_in(rd_ptr_in), .commit_ptr_out(commit_ptr_out), .pkt_committed(pkt_committed)
`ifdef SRAM_OQ_WR_STATS_EN
    , .stat_pkt_in(stat_pkt_in), .stat_pkt_drop(stat_pkt_drop), .stat_trunc(stat_trunc)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [18:0]  addr;
    logic [255:0] data;
    logic [31:0]  strb;
  } wr_t;

  typedef struct {
    logic [4:0]  dst;
    int          len;
    int          nbeats;
    int          ack_mode;
    int          q;
    int          exp_wr;
    logic [16:0] exp_commit;
    int          exp_pulse;
  } vec_t;

  wr_t         exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          n_wr = 0;
  int          tag = 0;
  int          pulse_cnt [NQ] = '{default: 0};
  logic [16:0] m_wr     [NQ] = '{default: '0};
  logic [16:0] m_commit [NQ] = '{default: '0};
  logic [16:0] m_rd     [NQ] = '{default: '0};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_rd(input int q, input logic [16:0] v);
    m_rd[q] = v;
    rd_ptr_in[q*PW +: PW] = v;
  endtask

  // Drives beats 0..stop_after-1 and pushes the writes the spec'd admission rule predicts.
  task automatic send_pkt(input logic [4:0] dst, input int len, input int nbeats,
                          input int ack_mode, input int stop_after);
    int          q;
    int          cyc;
    logic [16:0] words;
    logic [16:0] free;
    bit          admit, rolled, ack_t, done;
    wr_t         w;
    q = 0;
    for (int i = NQ - 1; i >= 0; i--) if (dst[i]) q = i;
    words  = 17'((len + 31) >> 5);
    free   = 17'h10000 - (m_wr[q] - m_rd[q]);
    admit  = (dst != 5'd0) && (len != 0) && (words <= free);
    rolled = 1'b0;
    ack_t  = 1'b1;
    for (int b = 0; b < stop_after; b++) begin
      tag++;
      s_axis_tdata  = {8{32'(tag)}};
      s_axis_tstrb  = 32'(tag) ^ 32'hA5A5_0F0F;
      s_axis_tuser  = '0;
      s_axis_tuser[15:0]  = 16'(len);
      s_axis_tuser[28:24] = dst;
      s_axis_tlast  = (b == nbeats - 1);
      s_axis_tvalid = 1'b1;
      if (admit && !rolled) begin
        free = 17'h10000 - (m_wr[q] - m_rd[q]);
        if (!s_axis_tlast && free == 17'd0) begin
          rolled  = 1'b1;
          m_wr[q] = m_commit[q];
        end else begin
          w.addr = 19'((q << 16) | int'(m_wr[q][15:0]));
          w.data = s_axis_tdata;
          w.strb = s_axis_tstrb;
          exp_q.push_back(w);
          m_wr[q] = m_wr[q] + 17'd1;
          if (s_axis_tlast) m_commit[q] = m_wr[q];
        end
      end
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 50) begin
        mem_wr_ack = (ack_mode == 0) ? 1'b1 : ack_t;
        @(negedge aclk);
        done = s_axis_tready;
        @(posedge aclk);
        #1;
        ack_t = !ack_t;
        cyc++;
      end
      chk("beat_accepted", 256'(done), 256'd1);
    end
    if (stop_after == nbeats) begin
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      mem_wr_ack    = 1'b0;
    end
  endtask

  // Write scoreboard and commit-pulse counter, sampled mid-cycle.
  always @(negedge aclk) begin
    wr_t w;
    if (aresetn === 1'b1 && mem_wr_req === 1'b1 && mem_wr_ack === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h expected no write", mem_wr_addr);
      end else begin
        w = exp_q.pop_front();
        chk("wr_addr", 256'(mem_wr_addr), 256'(w.addr));
        chk("wr_data", mem_wr_data, w.data);
        chk("wr_strb", 256'(mem_wr_strb), 256'(w.strb));
      end
    end
    for (int i = 0; i < NQ; i++) if (pkt_committed[i] === 1'b1) pulse_cnt[i]++;
  end

  initial begin
    vec_t vt [7];
    int   wr0;
    int   p0;
    vt[0] = '{5'h04,  64, 2, 0, 2, 2, 17'd2, 1};
    vt[1] = '{5'h00,  96, 3, 0, 0, 0, 17'd0, 0};
    vt[2] = '{5'h08, 128, 4, 1, 3, 4, 17'd4, 1};
    vt[3] = '{5'h01,   0, 1, 0, 0, 0, 17'd0, 0};
    vt[4] = '{5'h18,  33, 2, 0, 3, 2, 17'd6, 1};
    vt[5] = '{5'h10,   1, 1, 1, 4, 1, 17'd1, 1};
    vt[6] = '{5'h01,  32, 1, 0, 0, 1, 17'd1, 1};

    aresetn = 1'b0;
    s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; mem_wr_ack = 1'b0;
    rd_ptr_in = '0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tready", 256'(s_axis_tready), 256'd0);
    chk("rst_req", 256'(mem_wr_req), 256'd0);
    chk("rst_pulse", 256'(pkt_committed), 256'd0);
    chk("rst_commit", 256'(commit_ptr_out), 256'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    for (int i = 0; i < 7; i++) begin
      wr0 = n_wr;
      p0  = pulse_cnt[vt[i].q];
      send_pkt(vt[i].dst, vt[i].len, vt[i].nbeats, vt[i].ack_mode, vt[i].nbeats);
      repeat (2) @(negedge aclk);
      chk($sformatf("vec%0d_writes", i), 256'(n_wr - wr0), 256'(vt[i].exp_wr));
      chk($sformatf("vec%0d_commit", i), 256'(commit_ptr_out[vt[i].q*PW +: PW]), 256'(vt[i].exp_commit));
      chk($sformatf("vec%0d_pulses", i), 256'(pulse_cnt[vt[i].q] - p0), 256'(vt[i].exp_pulse));
      @(posedge aclk);
      #1;
    end

    // Fill queue 1 to 65534 words, then an oversize packet drops and an exact fit commits across the wrap.
    p0 = pulse_cnt[1];
    for (int k = 0; k < 31; k++) send_pkt(5'h02, 65535, 2048, 0, 2048);
    send_pkt(5'h02, 65472, 2046, 0, 2046);
    repeat (2) @(negedge aclk);
    chk("fill_commit", 256'(commit_ptr_out[1*PW +: PW]), 256'h0FFFE);
    chk("fill_pulses", 256'(pulse_cnt[1] - p0), 256'd32);
    @(posedge aclk);
    #1;
    wr0 = n_wr;
    send_pkt(5'h02, 96, 3, 0, 3);
    repeat (2) @(negedge aclk);
    chk("full_drop_writes", 256'(n_wr - wr0), 256'd0);
    chk("full_drop_commit", 256'(commit_ptr_out[1*PW +: PW]), 256'h0FFFE);
    @(posedge aclk);
    #1;
    p0 = pulse_cnt[1];
    send_pkt(5'h02, 64, 2, 0, 2);
    repeat (2) @(negedge aclk);
    chk("wrap_commit", 256'(commit_ptr_out[1*PW +: PW]), 256'h10000);
    chk("wrap_pulse", 256'(pulse_cnt[1] - p0), 256'd1);
    @(posedge aclk);
    #1;

    // Overrun: declared 1 word into 1 free word but 3 beats arrive.
    set_rd(1, 17'd1);
    wr0 = n_wr;
    p0  = pulse_cnt[1];
    send_pkt(5'h02, 32, 3, 0, 3);
    repeat (2) @(negedge aclk);
    chk("trunc_writes", 256'(n_wr - wr0), 256'd1);
    chk("trunc_commit", 256'(commit_ptr_out[1*PW +: PW]), 256'h10000);
    chk("trunc_pulse", 256'(pulse_cnt[1] - p0), 256'd0);
    @(posedge aclk);
    #1;
    send_pkt(5'h02, 32, 1, 0, 1);
    repeat (2) @(negedge aclk);
    chk("after_trunc_commit", 256'(commit_ptr_out[1*PW +: PW]), 256'h10001);
    @(posedge aclk);
    #1;

    // Reset during WRITE after two accepted beats.
    send_pkt(5'h01, 128, 4, 0, 2);
    tag++;
    s_axis_tdata  = {8{32'(tag)}};
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b0;
    mem_wr_ack    = 1'b1;
    #2;
    chk("pre_reset_req", 256'(mem_wr_req), 256'd1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_tready", 256'(s_axis_tready), 256'd0);
    chk("mid_rst_req", 256'(mem_wr_req), 256'd0);
    chk("mid_rst_commit", 256'(commit_ptr_out), 256'd0);
    chk("mid_rst_pending", 256'(exp_q.size()), 256'd0);
    s_axis_tvalid = 1'b0;
    mem_wr_ack    = 1'b0;
    for (int i = 0; i < NQ; i++) begin
      m_wr[i]     = '0;
      m_commit[i] = '0;
      set_rd(i, 17'd0);
    end
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    send_pkt(5'h02, 32, 1, 0, 1);
    repeat (2) @(negedge aclk);
    chk("post_rst_commit", 256'(commit_ptr_out[1*PW +: PW]), 256'd1);
    chk("end_pending", 256'(exp_q.size()), 256'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
